// File: rtl/hashmap_arbiter.sv
// hashmap_arbiter: round-robin burst arbiter that shares a single hashmap
// (write / lookup / clear ports) between NUM_REQ streaming requesters.
// A requester owns the hashmap from its grant until its req_last beat, which
// also clears the map for the next burst. Stalls hold ownership.
// Optional feature macro: HASHMAP_ARB_TIMEOUT_EN ends a burst after TIMEOUT
// consecutive stalled cycles and pulses `timeout`.
module hashmap_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int KEY_WIDTH   = 2,
  parameter int VALUE_WIDTH = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_wkey,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0] req_wvalue,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_rkey,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic                           resp_hit,
  output logic [VALUE_WIDTH-1:0]         resp_value,
  output logic                           resp_collision,
  output logic                           timeout,
  output logic                           hm_write_request,
  output logic [KEY_WIDTH-1:0]           hm_write_key,
  output logic [VALUE_WIDTH-1:0]         hm_write_value,
  output logic [KEY_WIDTH-1:0]           hm_read_key,
  input  logic                           hm_collision,
  input  logic [VALUE_WIDTH-1:0]         hm_read_value,
  input  logic                           hm_read_response,
  output logic                           hm_clear_cache
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Reject nonsensical configurations at elaboration time.
  if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("hashmap_arbiter: NUM_REQ must be >= 2 and TIMEOUT >= 1");
  end

  logic [0:0]       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] owner_inc;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick;
  logic             pick_found;
  logic             busy;
  logic             beat;
  logic             tmo_fire;
  logic             burst_end;

  assign busy      = (state == BUSY);
  assign beat      = busy & req_valid[owner];
  assign burst_end = (beat & req_last[owner]) | tmo_fire;
  assign owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

  // Round-robin scan: first valid requester starting at rr_ptr, wrapping.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick       = idx[IDX_W-1:0];
        pick_found = 1'b1;
      end
    end
  end

  // Hashmap ports follow the owner's slice while BUSY and rest at 0 otherwise.
  always_comb begin
    hm_write_request = beat & req_we[owner];
    hm_write_key     = '0;
    hm_write_value   = '0;
    hm_read_key      = '0;
    if (busy) begin
      hm_write_key   = req_wkey[int'(owner)*KEY_WIDTH +: KEY_WIDTH];
      hm_write_value = req_wvalue[int'(owner)*VALUE_WIDTH +: VALUE_WIDTH];
      hm_read_key    = req_rkey[int'(owner)*KEY_WIDTH +: KEY_WIDTH];
    end
  end

  // The clear is issued on the cycle the burst ends, after this beat's access.
  assign hm_clear_cache = burst_end;

  // Ownership FSM: IDLE picks an owner, BUSY holds it until the burst ends.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state <= BUSY;
            owner <= pick;
            grant <= NUM_REQ'(1) << pick;
          end
        end
        default: begin
          if (burst_end) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= owner_inc;
          end
        end
      endcase
    end
  end

  // One-cycle response: strobe the owner and capture lookup/collision results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid     <= '0;
      resp_hit       <= 1'b0;
      resp_value     <= '0;
      resp_collision <= 1'b0;
    end else if (beat) begin
      resp_valid     <= grant;
      resp_hit       <= hm_read_response;
      resp_value     <= hm_read_value;
      resp_collision <= hm_collision & hm_write_request;
    end else begin
      resp_valid     <= '0;
    end
  end

`ifdef HASHMAP_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt;

  // Fires on the TIMEOUT-th consecutive stalled cycle of the owner.
  assign tmo_fire = busy & ~req_valid[owner] & (idle_cnt == CNT_W'(TIMEOUT - 1));

  // Count consecutive stalled BUSY cycles; the timeout flag is a registered pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= tmo_fire;
      if (!busy || req_valid[owner] || tmo_fire) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_hashmap_arbiter.sv
// tb_hashmap_arbiter: directed scenarios followed by random traffic, each
// cycle compared against a burst-level reference model of the arbiter and a
// small behavioural hashmap that answers the DUT's hashmap ports.
module tb_hashmap_arbiter;

  localparam int N   = 4;
  localparam int K   = 2;
  localparam int V   = 2;
  localparam int TMO = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid, req_last, req_we;
  logic [N*K-1:0] req_wkey, req_rkey;
  logic [N*V-1:0] req_wvalue;
  logic [N-1:0]   grant, resp_valid;
  logic           resp_hit, resp_collision, timeout;
  logic [V-1:0]   resp_value;
  logic           hm_write_request, hm_collision, hm_read_response, hm_clear_cache;
  logic [K-1:0]   hm_write_key, hm_read_key;
  logic [V-1:0]   hm_write_value, hm_read_value;

  int n_tests = 0;
  int n_fail  = 0;

  hashmap_arbiter #(.NUM_REQ(N), .KEY_WIDTH(K), .VALUE_WIDTH(V), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_we(req_we),
    .req_wkey(req_wkey), .req_wvalue(req_wvalue), .req_rkey(req_rkey),
    .grant(grant), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_value(resp_value), .resp_collision(resp_collision), .timeout(timeout),
    .hm_write_request(hm_write_request), .hm_write_key(hm_write_key),
    .hm_write_value(hm_write_value), .hm_read_key(hm_read_key),
    .hm_collision(hm_collision), .hm_read_value(hm_read_value),
    .hm_read_response(hm_read_response), .hm_clear_cache(hm_clear_cache)
  );

  always #5 clk = ~clk;

  // Behavioural hashmap: direct-mapped by key, lookups see the pre-write map.
  logic         map_vld [1<<K];
  logic [V-1:0] map_val [1<<K];

  assign hm_read_response = map_vld[hm_read_key];
  assign hm_read_value    = map_val[hm_read_key];
  assign hm_collision     = hm_write_request & map_vld[hm_write_key];

  always @(posedge clk) begin
    if (hm_clear_cache) begin
      for (int i = 0; i < (1<<K); i++) map_vld[i] <= 1'b0;
    end else if (hm_write_request) begin
      map_vld[hm_write_key] <= 1'b1;
      map_val[hm_write_key] <= hm_write_value;
    end
  end

  // Reference model: current owner (-1 = none), round-robin start, expected responses.
  int           m_owner = -1;
  int           m_rr    = 0;
  int           m_stall = 0;
  logic [N-1:0] e_rv    = '0;
  logic         e_hit   = 1'b0;
  logic [V-1:0] e_val   = '0;
  logic         e_col   = 1'b0;
  logic         e_to    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_we     = '0;
    req_wkey   = '0;
    req_wvalue = '0;
    req_rkey   = '0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_resp_value", resp_value, 0);
    check("rst_resp_collision", resp_collision, 0);
    check("rst_timeout", timeout, 0);
    m_owner = -1;
    m_rr    = 0;
    m_stall = 0;
    e_rv    = '0;
    e_hit   = 1'b0;
    e_val   = '0;
    e_col   = 1'b0;
    e_to    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: check registered outputs, drive a beat, check the
  // combinational hashmap ports, then advance the model across the next edge.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N-1:0] w,
                      input logic [N*K-1:0] wk, input logic [N*V-1:0] wv,
                      input logic [N*K-1:0] rk);
    logic         acc, fire, e_wr, e_clr;
    logic [K-1:0] e_wk, e_rk;
    logic [V-1:0] e_wv;
    @(negedge clk);
    check("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
    check("resp_valid", resp_valid, e_rv);
    check("resp_hit", resp_hit, e_hit);
    check("resp_value", resp_value, e_val);
    check("resp_collision", resp_collision, e_col);
    check("timeout", timeout, e_to);
    req_valid = v; req_last = l; req_we = w;
    req_wkey = wk; req_wvalue = wv; req_rkey = rk;
    #1;
    acc = 1'b0; fire = 1'b0; e_wr = 1'b0; e_wk = '0; e_wv = '0; e_rk = '0;
    if (m_owner >= 0) begin
      acc  = v[m_owner];
      e_wr = acc & w[m_owner];
      e_wk = wk[m_owner*K +: K];
      e_wv = wv[m_owner*V +: V];
      e_rk = rk[m_owner*K +: K];
`ifdef HASHMAP_ARB_TIMEOUT_EN
      fire = !acc && (m_stall + 1 == TMO);
`endif
    end
    e_clr = (acc & l[m_owner < 0 ? 0 : m_owner]) | fire;
    check("hm_write_request", hm_write_request, e_wr);
    check("hm_write_key", hm_write_key, e_wk);
    check("hm_write_value", hm_write_value, e_wv);
    check("hm_read_key", hm_read_key, e_rk);
    check("hm_clear_cache", hm_clear_cache, e_clr);
    e_to = fire;
    e_rv = '0;
    if (m_owner >= 0) begin
      if (acc) begin
        e_rv    = N'(1) << m_owner;
        e_hit   = map_vld[e_rk];
        e_val   = map_val[e_rk];
        e_col   = e_wr & map_vld[e_wk];
        m_stall = 0;
      end else begin
        m_stall++;
      end
      if (e_clr) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
        m_stall = 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && v[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
      end
    end
  endtask

  // Drive one requester's beat with all other requesters silent.
  task automatic beat_of(input int r, input logic v, input logic l, input logic w,
                         input int wk, input int wv, input int rk);
    logic [N*K-1:0] wkv, rkv;
    logic [N*V-1:0] wvv;
    wkv = '0; rkv = '0; wvv = '0;
    wkv[r*K +: K] = K'(wk);
    wvv[r*V +: V] = V'(wv);
    rkv[r*K +: K] = K'(rk);
    step(N'(v) << r, N'(l) << r, N'(w) << r, wkv, wvv, rkv);
  endtask

  initial begin
    for (int i = 0; i < (1<<K); i++) begin
      map_vld[i] = 1'b0;
      map_val[i] = '0;
    end
    #2;
    apply_reset();

    // Single stream, target 1: wkey 1,0,3 with rkey 0,1,2; second beat hits value 0.
    beat_of(0, 1, 0, 0, 0, 0, 0);
    beat_of(0, 1, 0, 1, 1, 0, 0);
    beat_of(0, 1, 0, 1, 0, 1, 1);
    beat_of(0, 1, 1, 1, 3, 2, 2);
    beat_of(0, 0, 0, 0, 0, 0, 0);
    check("t1_second_hit_seen", 32'(e_hit), 0);

    // Contention: all valid, two-beat bursts, order 0,1,2,3,0 with an IDLE gap.
    for (int c = 0; c < 15; c++) begin
      step('1, (c % 3 == 2) ? '1 : '0, '1, N*K'($urandom), N*V'($urandom), N*K'($urandom));
    end

    // Non-owner beats: requester 1 owns while requester 2 writes; 2 is served next.
    beat_of(1, 1, 0, 0, 0, 0, 0);
    step(4'b0110, 4'b0100, 4'b0100, 8'h30, 8'h30, 8'h00);
    step(4'b0110, 4'b0110, 4'b0100, 8'h30, 8'h30, 8'h00);
    step(4'b0100, 4'b0000, 4'b0100, 8'h20, 8'h10, 8'h00);
    beat_of(2, 1, 1, 1, 1, 1, 1);

    // Collision: requester 3 writes key 2 twice within one burst.
    beat_of(3, 1, 0, 0, 0, 0, 0);
    beat_of(3, 1, 0, 1, 2, 1, 0);
    beat_of(3, 1, 0, 1, 2, 3, 2);
    beat_of(3, 1, 1, 0, 0, 0, 2);
    beat_of(3, 0, 0, 0, 0, 0, 0);

    // Reset during the second beat; afterwards requester 0 wins a full contention.
    beat_of(1, 1, 0, 0, 0, 0, 0);
    beat_of(1, 1, 0, 1, 1, 1, 0);
    beat_of(1, 1, 0, 1, 2, 2, 1);
    apply_reset();
    step('1, '0, '0, '0, '0, '0);
    step('1, '1, '0, '0, '0, '0);
    step('0, '0, '0, '0, '0, '0);

    // Random traffic with short bursts, stalls and mixed read/write beats.
    for (int c = 0; c < 400; c++) begin
      step(N'($urandom), N'($urandom & $urandom), N'($urandom),
           N*K'($urandom), N*V'($urandom), N*K'($urandom));
    end
    step('0, '0, '0, '0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
